// File: rtl/bus_master.sv
`default_nettype none
// ============================================================================
// bus_master : H-bus initiator, arbitrates fetch and data requests onto the bus
//              with lane handling, alignment check and WAIT timeout.
// Revision   : 1.0
// ============================================================================
module bus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Hclock,
  input  logic        Hreset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_data,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_write,
  input  logic        dm_size,
  input  logic        dm_signed,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        dm_misalign,
  output logic [31:0] Haddress,
  output logic        Hwrite,
  output logic        Hsize,
  output logic [31:0] Hwritedata,
  input  logic [31:0] Hreaddata,
  input  logic        Hresponse,
  input  logic        Hready,
  output logic        busy
);

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_data_q, is_data_d;
  logic        signed_q, signed_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic        hsize_q, hsize_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        if_ack_q, if_ack_d;
  logic        if_err_q, if_err_d;
  logic [31:0] if_data_q, if_data_d;
  logic        dm_ack_q, dm_ack_d;
  logic        dm_err_q, dm_err_d;
  logic        dm_mis_q, dm_mis_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  logic [31:0] w_shifted;
  logic [31:0] w_load_val;
  logic        w_done;
  logic        w_done_err;

  // Byte loads pick the lane addressed by the latched low address bits.
  always_comb begin
    w_shifted = Hreaddata >> {haddr_q[1:0], 3'b000};
    if (hsize_q) begin
      w_load_val = Hreaddata;
    end else begin
      w_load_val = {{24{signed_q & w_shifted[7]}}, w_shifted[7:0]};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_data_d  = is_data_q;
    signed_d   = signed_q;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hwdata_d   = hwdata_q;
    if_ack_d   = 1'b0;
    if_err_d   = 1'b0;
    if_data_d  = if_data_q;
    dm_ack_d   = 1'b0;
    dm_err_d   = 1'b0;
    dm_mis_d   = 1'b0;
    dm_rdata_d = dm_rdata_q;
    w_done     = 1'b0;
    w_done_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dm_req) begin
          if (dm_size && (dm_addr[1:0] != 2'b00)) begin
            dm_ack_d   = 1'b1;
            dm_err_d   = 1'b1;
            dm_mis_d   = 1'b1;
            dm_rdata_d = '0;
          end else begin
            state_d   = S_ADDR;
            cnt_d     = '0;
            is_data_d = 1'b1;
            signed_d  = dm_signed;
            haddr_d   = dm_addr;
            hwrite_d  = dm_write;
            hsize_d   = dm_size;
            if (!dm_write) begin
              hwdata_d = '0;
            end else if (dm_size) begin
              hwdata_d = dm_wdata;
            end else begin
              hwdata_d = {4{dm_wdata[7:0]}};
            end
          end
        end else if (if_req) begin
          state_d   = S_ADDR;
          cnt_d     = '0;
          is_data_d = 1'b0;
          signed_d  = 1'b0;
          haddr_d   = if_addr;
          hwrite_d  = 1'b0;
          hsize_d   = 1'b1;
          hwdata_d  = '0;
        end
      end
      S_ADDR: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Hready) begin
          w_done     = 1'b1;
          w_done_err = Hresponse;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == c_timeout) begin
            w_done     = 1'b1;
            w_done_err = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_done) begin
      state_d  = S_IDLE;
      hwrite_d = 1'b0;
      if (is_data_q) begin
        dm_ack_d   = 1'b1;
        dm_err_d   = w_done_err;
        dm_rdata_d = w_done_err ? 32'd0 : w_load_val;
      end else begin
        if_ack_d  = 1'b1;
        if_err_d  = w_done_err;
        if_data_d = w_done_err ? 32'd0 : Hreaddata;
      end
    end
  end

  always_ff @(posedge Hclock) begin
    if (Hreset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_data_q  <= 1'b0;
      signed_q   <= 1'b0;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hsize_q    <= 1'b1;
      hwdata_q   <= '0;
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      if_data_q  <= '0;
      dm_ack_q   <= 1'b0;
      dm_err_q   <= 1'b0;
      dm_mis_q   <= 1'b0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_data_q  <= is_data_d;
      signed_q   <= signed_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hwdata_q   <= hwdata_d;
      if_ack_q   <= if_ack_d;
      if_err_q   <= if_err_d;
      if_data_q  <= if_data_d;
      dm_ack_q   <= dm_ack_d;
      dm_err_q   <= dm_err_d;
      dm_mis_q   <= dm_mis_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign Haddress    = haddr_q;
  assign Hwrite      = hwrite_q;
  assign Hsize       = hsize_q;
  assign Hwritedata  = hwdata_q;
  assign if_ack      = if_ack_q;
  assign if_err      = if_err_q;
  assign if_data     = if_data_q;
  assign dm_ack      = dm_ack_q;
  assign dm_err      = dm_err_q;
  assign dm_misalign = dm_mis_q;
  assign dm_rdata    = dm_rdata_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_master.sv
`default_nettype none
// ============================================================================
// tb_bus_master : directed bench with a transaction-level timing/data model.
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bus_master;

  localparam int TO = 4;

  logic        Hclock = 1'b0;
  logic        Hreset;
  logic        if_req, dm_req, dm_write, dm_size, dm_signed;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, if_err, dm_ack, dm_err, dm_misalign;
  logic [31:0] if_data, dm_rdata;
  logic [31:0] Haddress, Hwritedata, Hreaddata;
  logic        Hwrite, Hsize, Hresponse, Hready, busy;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;
  int rdy0 = -1;
  int rdy1 = -1;
  bit chk_en = 1'b0;

  always #5 Hclock = ~Hclock;
  always @(posedge Hclock) edges <= edges + 1;

  // Hready is high exactly for the edge numbered rdy0/rdy1.
  assign Hready = (edges + 1 == rdy0) || (edges + 1 == rdy1);

  bus_master #(.TIMEOUT(TO)) dut (
    .Hclock(Hclock), .Hreset(Hreset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data), .if_err(if_err),
    .dm_req(dm_req), .dm_write(dm_write), .dm_size(dm_size), .dm_signed(dm_signed),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .dm_err(dm_err), .dm_misalign(dm_misalign),
    .Haddress(Haddress), .Hwrite(Hwrite), .Hsize(Hsize), .Hwritedata(Hwritedata),
    .Hreaddata(Hreaddata), .Hresponse(Hresponse), .Hready(Hready), .busy(busy)
  );

  typedef struct {
    int          a;
    int          c;
    bit          is_data;
    bit          wr;
    bit          sz;
    bit          mis;
    bit          err;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] data;
  } txn_t;

  txn_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edges);
    end
  endtask

  // Accepted at edge a; completes at edge c; ack visible in the cycle after c.
  function automatic txn_t model(input bit is_data, input bit wr, input bit sz, input bit sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int a, input int w, input logic [31:0] rd, input bit resp);
    txn_t t;
    int   bval;
    t.a = a; t.is_data = is_data; t.addr = addr; t.mis = 1'b0;
    t.wr = is_data && wr;
    t.sz = is_data ? sz : 1'b1;
    t.wd = 32'd0; t.data = 32'd0; t.err = 1'b0;
    if (is_data && sz && addr[1:0] != 2'b00) begin
      t.mis = 1'b1; t.err = 1'b1; t.c = a; t.wr = 1'b0;
      return t;
    end
    if (t.wr) t.wd = sz ? wdata : (wdata & 32'hFF) * 32'h01010101;
    if (w >= TO) begin
      t.c = a + 1 + TO; t.err = 1'b1;
    end else begin
      t.c = a + 2 + w; t.err = resp;
    end
    if (t.err) t.data = 32'd0;
    else if (!t.is_data || t.sz) t.data = rd;
    else begin
      bval = int'((rd >> (8 * addr[1:0])) & 32'hFF);
      t.data = (sgn && bval >= 128) ? 32'(bval - 256) : 32'(bval);
    end
    return t;
  endfunction

  always @(negedge Hclock) begin
    bit   busy_e, dma_e, ifa_e;
    txn_t h;
    busy_e = 1'b0; dma_e = 1'b0; ifa_e = 1'b0;
    if (chk_en) begin
      if (q.size() > 0) begin
        h = q[0];
        busy_e = !h.mis && edges >= h.a && edges < h.c;
        dma_e  = (edges == h.c) && h.is_data;
        ifa_e  = (edges == h.c) && !h.is_data;
      end
      chk("busy", busy, busy_e);
      chk("Hwrite", Hwrite, busy_e && h.wr);
      chk("dm_ack", dm_ack, dma_e);
      chk("if_ack", if_ack, ifa_e);
      if (busy_e) begin
        chk("Haddress", Haddress, h.addr);
        chk("Hsize", Hsize, h.sz);
        chk("Hwritedata", Hwritedata, h.wd);
      end
      if (dma_e) begin
        chk("dm_err", dm_err, h.err);
        chk("dm_misalign", dm_misalign, h.mis);
        if (!h.wr) chk("dm_rdata", dm_rdata, h.data);
      end
      if (ifa_e) begin
        chk("if_err", if_err, h.err);
        chk("if_data", if_data, h.data);
      end
      if (q.size() > 0 && edges == q[0].c) void'(q.pop_front());
    end
  end

  task automatic issue(input bit is_data, input bit wr, input bit sz, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input int w,
                       input logic [31:0] rd, input bit resp);
    txn_t t;
    @(posedge Hclock); #1;
    t = model(is_data, wr, sz, sgn, addr, wd, edges + 1, w, rd, resp);
    q.push_back(t);
    Hreaddata = rd; Hresponse = resp;
    rdy0 = (t.mis || w >= TO) ? -1 : t.c;
    if (is_data) begin
      dm_req = 1'b1; dm_write = wr; dm_size = sz; dm_signed = sgn;
      dm_addr = addr; dm_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    repeat (t.c - edges) @(posedge Hclock);
    #1;
    dm_req = 1'b0; if_req = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_Hwrite"}, Hwrite, 1'b0);
    chk({tag, "_Hsize"}, Hsize, 1'b1);
    chk({tag, "_Haddress"}, Haddress, 32'd0);
    chk({tag, "_Hwritedata"}, Hwritedata, 32'd0);
    chk({tag, "_acks"}, {if_ack, dm_ack, if_err, dm_err, dm_misalign}, 5'd0);
    chk({tag, "_if_data"}, if_data, 32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    txn_t t1, t2;
    Hreset = 1'b1;
    if_req = 0; dm_req = 0; dm_write = 0; dm_size = 0; dm_signed = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; Hreaddata = 0; Hresponse = 0;
    repeat (3) @(posedge Hclock);
    #1;
    chk_reset_vals("rst");
    Hreset = 1'b0;
    chk_en = 1'b1;

    // Fetch with two wait cycles
    issue(0, 0, 1, 0, 32'h1FC00010, 32'd0, 2, 32'h3C08BFD0, 0);
    chk("fetch_lit_data", if_data, 32'h3C08BFD0);
    chk("fetch_lit_err", if_err, 1'b0);

    // Data has priority; the fetch is taken on the next IDLE
    @(posedge Hclock); #1;
    t1 = model(1, 0, 1, 0, 32'h00000100, 32'd0, edges + 1, 1, 32'hCAFEF00D, 0);
    t2 = model(0, 0, 1, 0, 32'h1FC00020, 32'd0, t1.c + 1, 0, 32'h24080001, 0);
    q.push_back(t1); q.push_back(t2);
    rdy0 = t1.c; rdy1 = t2.c;
    Hreaddata = 32'hCAFEF00D; Hresponse = 0;
    dm_req = 1; dm_write = 0; dm_size = 1; dm_signed = 0; dm_addr = 32'h00000100;
    if_req = 1; if_addr = 32'h1FC00020;
    repeat (t1.c - edges) @(posedge Hclock);
    #1;
    chk("prio_dm_first", {dm_ack, if_ack}, 2'b10);
    chk("prio_lit_rdata", dm_rdata, 32'hCAFEF00D);
    dm_req = 0;
    Hreaddata = 32'h24080001;
    repeat (t2.c - edges) @(posedge Hclock);
    #1;
    chk("prio_if_second", {dm_ack, if_ack}, 2'b01);
    if_req = 0; rdy1 = -1;

    // Byte loads: signed/unsigned on lane 3, unsigned lane 1, signed positive lane 2
    issue(1, 0, 0, 1, 32'h00000003, 32'd0, 0, 32'h80ABCD12, 0);
    chk("sbyte_lit", dm_rdata, 32'hFFFFFF80);
    issue(1, 0, 0, 0, 32'h00000003, 32'd0, 1, 32'h80ABCD12, 0);
    chk("ubyte_lit", dm_rdata, 32'h00000080);
    issue(1, 0, 0, 0, 32'h00000011, 32'd0, 0, 32'h80ABCD12, 0);
    chk("lane1_lit", dm_rdata, 32'h000000CD);
    issue(1, 0, 0, 1, 32'h00000012, 32'd0, 0, 32'h807BCD12, 0);
    chk("lane2_lit", dm_rdata, 32'h0000007B);

    // Byte store replication, then a word store
    issue(1, 1, 0, 0, 32'h1FD003F8, 32'h123456A5, 1, 32'd0, 0);
    chk("bstore_lit_wdata", Hwritedata, 32'hA5A5A5A5);
    chk("bstore_lit_size", Hsize, 1'b0);
    chk("bstore_lit_hwrite", Hwrite, 1'b0);
    issue(1, 1, 1, 0, 32'h00000200, 32'hDEADBEEF, 0, 32'd0, 0);

    // Misaligned word store: no bus cycle
    issue(1, 1, 1, 0, 32'h00000006, 32'h11111111, 0, 32'd0, 0);
    chk("mis_lit", {dm_ack, dm_err, dm_misalign, Hwrite, busy}, 5'b11100);

    // Bus error response and timeout
    issue(1, 0, 1, 0, 32'h20000000, 32'd0, 0, 32'h55555555, 1);
    chk("buserr_lit", {dm_err, dm_misalign}, 2'b10);
    chk("buserr_lit_rdata", dm_rdata, 32'd0);
    issue(1, 0, 1, 0, 32'h00000040, 32'd0, TO, 32'h77777777, 0);
    chk("timeout_lit", {dm_ack, dm_err, dm_misalign}, 3'b110);
    issue(0, 0, 1, 0, 32'h1FC00004, 32'd0, 3, 32'h0BADF00D, 0);

    // Reset while waiting on the bus
    @(posedge Hclock); #1;
    chk_en = 1'b0;
    rdy0 = -1;
    dm_req = 1; dm_write = 1; dm_size = 1; dm_addr = 32'h00000300; dm_wdata = 32'h12345678;
    repeat (3) @(posedge Hclock);
    #1;
    chk("midwait_busy", {busy, Hwrite}, 2'b11);
    dm_req = 0;
    Hreset = 1'b1;
    @(posedge Hclock); #1;
    chk_reset_vals("midrst");
    Hreset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Hclock); #1;
      chk("post_rst_quiet", {dm_ack, if_ack, busy}, 3'b000);
    end

    chk("pending_txns", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
